// File: rtl/qft3_stream_scheduler.sv
// qft3_stream_scheduler: credit-based admission, in-flight tracking and FWFT result buffering
// around a free-running 3-qubit QFT pipeline.
module qft3_stream_scheduler #(
    parameter int DATA_W     = 16,
    parameter int LATENCY    = 19,
    parameter int FIFO_DEPTH = 32,
    parameter int TAG_W      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [16*DATA_W-1:0]              in_data,
    input  logic [TAG_W-1:0]                  in_tag,
    input  logic                              flush,
    output logic                              flush_done,
    output logic                              dp_rst_n,
    output logic [16*DATA_W-1:0]              dp_in,
    input  logic [16*DATA_W-1:0]              dp_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [16*DATA_W-1:0]              out_data,
    output logic [TAG_W-1:0]                  out_tag,
    output logic                              busy,
    output logic [$clog2(LATENCY+1)-1:0]      inflight_cnt,
    output logic [15:0]                       frame_cnt
);
    localparam int W    = 16*DATA_W;
    localparam int CW   = $clog2(LATENCY+1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int FCW  = AW + 1;
    localparam int SW   = CW + AW + 1;

    typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic                 dp_rst_n_q;
    logic [W-1:0]         dp_in_q;
    logic [LATENCY-1:0]   sv_q;
    logic [TAG_W-1:0]     st_q [LATENCY];
    logic [W+TAG_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [FCW-1:0]       fifo_cnt_q;
    logic [CW-1:0]        infl_q;
    logic [15:0]          frame_q;
    logic                 accept, push, pop, empty, full, credit_ok;
    logic [SW-1:0]        outstanding;

    assign empty       = fifo_cnt_q == '0;
    assign full        = fifo_cnt_q == FCW'(FIFO_DEPTH);
    assign push        = sv_q[LATENCY-1];
    assign pop         = out_valid && out_ready;
    assign accept      = in_valid && in_ready;
    // Registered counts only, so a frame admitted now always has a FIFO slot reserved.
    assign outstanding = SW'(infl_q) + SW'(fifo_cnt_q);
    assign credit_ok   = outstanding < SW'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            INIT:    state_d = RUN;
            RUN: begin
                in_ready = !flush && credit_ok;
                state_d  = flush ? DRAIN : RUN;
            end
            DRAIN: begin
                flush_done = infl_q == '0 && empty;
                state_d    = flush_done ? RUN : DRAIN;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            dp_rst_n_q <= 1'b0;
            dp_in_q    <= '0;
            sv_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            fifo_cnt_q <= '0;
            infl_q     <= '0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            dp_rst_n_q <= 1'b1;
            dp_in_q    <= accept ? in_data : '0;
            sv_q       <= {sv_q[LATENCY-2:0], accept};
            wr_q       <= wr_q + AW'(push);
            rd_q       <= rd_q + AW'(pop);
            fifo_cnt_q <= fifo_cnt_q + FCW'(push) - FCW'(pop);
            infl_q     <= infl_q + CW'(accept) - CW'(push);
            frame_q    <= frame_q + 16'(accept);
        end
    end

    // Tags and storage carry no reset; validity lives in sv_q and fifo_cnt_q.
    always_ff @(posedge clk) begin
        st_q[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) st_q[i] <= st_q[i-1];
        if (push) mem_q[wr_q] <= {st_q[LATENCY-1], dp_out};
    end

    assert property (@(posedge clk) disable iff (rst) !(push && full));

    assign out_valid              = !empty;
    assign {out_tag, out_data}    = out_valid ? mem_q[rd_q] : '0;
    assign dp_rst_n               = dp_rst_n_q;
    assign dp_in                  = dp_in_q;
    assign busy                   = infl_q != '0 || !empty;
    assign inflight_cnt           = infl_q;
    assign frame_cnt              = frame_q;
endmodule

// File: tb/tb_qft3_stream_scheduler.sv
// tb_qft3_stream_scheduler: directed bench with a stand-in datapath delay line and an expected-result queue.
module tb_qft3_stream_scheduler;
    localparam int DW = 16;
    localparam int L  = 19;
    localparam int D  = 32;
    localparam int TW = 4;
    localparam int W  = 16*DW;
    localparam int CW = $clog2(L+1);

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic in_ready, flush_done, dp_rst_n, out_valid, busy;
    logic [W-1:0] in_data = '0, dp_in, dp_out, out_data;
    logic [TW-1:0] in_tag = '0, out_tag;
    logic [CW-1:0] inflight_cnt;
    logic [15:0] frame_cnt;

    int passed = 0, total = 0;
    int acc_cnt = 0, pop_cnt = 0, fd_cnt = 0, cyc_n = 0, pop_first = -1, pop_last = -1, n;
    logic [W+TW-1:0] exp_q [$];
    logic [W-1:0] imp, exp1;
    logic [W+TW-1:0] e;

    always #5 clk = ~clk;

    qft3_stream_scheduler #(.DATA_W(DW), .LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tag(in_tag), .flush(flush), .flush_done(flush_done), .dp_rst_n(dp_rst_n),
        .dp_in(dp_in), .dp_out(dp_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy), .inflight_cnt(inflight_cnt),
        .frame_cnt(frame_cnt)
    );

    // Stand-in datapath: reals become a000_r/sqrt(8), imags pass through.
    function automatic logic [W-1:0] dp_func(input logic [W-1:0] d);
        logic [31:0] r;
        logic [W-1:0] o;
        r = ({16'd0, d[W-1 -: DW]} * 32'd1448) >> 12;
        o = '0;
        for (int k = 0; k < 8; k++) begin
            o[W-1-32*k -: DW]    = r[15:0];
            o[W-1-32*k-DW -: DW] = d[W-1-32*k-DW -: DW];
        end
        return o;
    endfunction

    function automatic logic [W-1:0] mk(input int i);
        logic [W-1:0] d;
        d = '0;
        d[W-1 -: DW] = 16'h1000 + 16'(i*16);
        for (int k = 0; k < 8; k++) d[W-1-32*k-DW -: DW] = 16'(i*8 + k + 1);
        return d;
    endfunction

    logic [W-1:0] pipe [L-1];
    always @(posedge clk) begin
        pipe[0] <= dp_rst_n ? dp_in : '0;
        for (int i = 1; i < L-1; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_out = dp_func(pipe[L-2]);

    task automatic chk(input string t, input logic [W+TW-1:0] o, input logic [W+TW-1:0] x);
        total++;
        assert (o === x) passed++;
        else $error("FAIL %s got %0h want %0h", t, o, x);
    endtask

    task automatic cyc();
        logic [W+TW-1:0] f;
        #2;
        if (in_valid && in_ready && !rst) begin
            acc_cnt++;
            exp_q.push_back({in_tag, dp_func(in_data)});
        end
        if (out_valid && out_ready && !rst) begin
            pop_cnt++;
            if (pop_first < 0) pop_first = cyc_n;
            pop_last = cyc_n;
            if (exp_q.size() == 0) chk("stale", out_valid, 0);
            else begin
                f = exp_q.pop_front();
                chk("odata", {out_tag, out_data}, f);
            end
        end
        fd_cnt += int'(flush_done);
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        cyc();
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_dp_rst_n", dp_rst_n, 0);
        chk("rst_dp_in", dp_in, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", {out_tag, out_data}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inflight", inflight_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_flush_done", flush_done, 0);
        cyc();
        chk("run_in_ready", in_ready, 1);
        chk("run_dp_rst_n", dp_rst_n, 1);

        // single impulse frame
        imp = '0;
        imp[W-1 -: DW] = 16'h1000;
        exp1 = '0;
        for (int k = 0; k < 8; k++) exp1[W-1-32*k -: DW] = 16'h05A8;
        in_valid = 1'b1; in_data = imp; in_tag = 4'd5;
        cyc();
        in_valid = 1'b0;
        chk("t1_inflight1", inflight_cnt, 1);
        n = 0;
        while (!out_valid && n < 100) begin cyc(); n++; end
        chk("t1_latency", n, L);
        chk("t1_tag", out_tag, 5);
        chk("t1_data", out_data, exp1);
        chk("t1_inflight0", inflight_cnt, 0);
        out_ready = 1'b1;
        cyc();
        chk("t1_out_valid", out_valid, 0);
        chk("t1_busy", busy, 0);

        // 40 back-to-back frames
        do_reset();
        acc_cnt = 0; pop_cnt = 0; pop_first = -1;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_data = mk(i); in_tag = TW'(i);
            cyc();
        end
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin cyc(); n++; end
        chk("t2_accepts", acc_cnt, 40);
        chk("t2_pops", pop_cnt, 40);
        chk("t2_contig", pop_last - pop_first + 1, 40);
        chk("t2_frame_cnt", frame_cnt, 40);
        chk("t2_busy", busy, 0);

        // backpressure fill to FIFO_DEPTH
        acc_cnt = 0; pop_cnt = 0;
        out_ready = 1'b0;
        for (int j = 0; j < 60; j++) begin
            in_valid = 1'b1; in_data = mk(100 + j); in_tag = TW'(j + 3);
            cyc();
        end
        in_valid = 1'b0;
        chk("t3_accepts", acc_cnt, D);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_inflight", inflight_cnt, 0);
        chk("t3_fifo_cnt", dut.fifo_cnt_q, D);
        chk("t3_out_valid", out_valid, 1);
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin cyc(); n++; end
        chk("t3_pops", pop_cnt, D);
        chk("t3_empty", out_valid, 0);

        // steady push+pop at 10 entries
        out_ready = 1'b0;
        n = 0;
        while (dut.fifo_cnt_q != 10 && n < 100) begin
            in_valid = 1'b1; in_data = mk(200 + n); in_tag = TW'(n);
            cyc(); n++;
        end
        chk("t4_fill", dut.fifo_cnt_q, 10);
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1; in_data = mk(300 + j); in_tag = TW'(j + 7);
            cyc();
            chk("t4_fifo_cnt", dut.fifo_cnt_q, 10);
            chk("t4_busy", busy, 1);
        end
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin cyc(); n++; end
        chk("t4_drained", busy, 0);

        // flush with 3 buffered and 5 in flight
        pop_cnt = 0; fd_cnt = 0;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_data = mk(400 + j); in_tag = TW'(j + 1);
            cyc();
        end
        in_valid = 1'b0;
        repeat (L + 2) cyc();
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1; in_data = mk(500 + j); in_tag = TW'(j + 9);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("t5_inflight", inflight_cnt, 5);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        chk("t5_in_ready_flush", in_ready, 0);
        cyc();
        flush = 1'b0;
        chk("t5_in_ready_drain", in_ready, 0);
        n = 0;
        while (fd_cnt == 0 && n < 100) begin cyc(); n++; end
        chk("t5_pops", pop_cnt, 8);
        chk("t5_flush_done", fd_cnt, 1);
        chk("t5_resume", in_ready, 1);
        cyc();
        chk("t5_single_pulse", fd_cnt, 1);

        // reset with 7 frames in flight
        for (int j = 0; j < 7; j++) begin
            in_valid = 1'b1; in_data = mk(600 + j); in_tag = TW'(j);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("t6_inflight", inflight_cnt, 7);
        rst = 1'b1;
        cyc();
        chk("t6_out_valid", out_valid, 0);
        chk("t6_inflight0", inflight_cnt, 0);
        chk("t6_dp_rst_n", dp_rst_n, 0);
        exp_q.delete();
        rst = 1'b0;
        pop_cnt = 0;
        repeat (2*L + 4) cyc();
        chk("t6_no_stale", pop_cnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_frame_cnt", frame_cnt, 0);
        chk("t6_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
